// File: rtl/jump_target_unit.sv
// Jump target assembler: collects a two-byte operand via put strobes and issues a
// one-cycle absolute-jump request to PC in ABS, ABS_IF or PC-relative mode.
module jump_target_unit #(
    parameter int unsigned D = 12
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         putEn,
    input  logic [7:0]   value,
    input  logic         jmpEn,
    input  logic         branchFlag,
    input  logic [D-1:0] prog_ctr,
    output logic [D-1:0] target,
    output logic         absjump_en,
    output logic         jump_taken,
    output logic         err,
    output logic [1:0]   pending
);

    typedef enum logic [1:0] {
        StEmpty = 2'd0,
        StLo    = 2'd1,
        StArmed = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        ModeAbs   = 2'b00,
        ModeAbsIf = 2'b01,
        ModeRel   = 2'b10,
        ModeRsvd  = 2'b11
    } mode_e;

    state_e       state_q;
    logic [7:0]   lo_q;
    logic [3:0]   hi_q;
    mode_e        mode_q;

    logic [D-1:0] abs_target;
    logic [D-1:0] rel_target;
    logic         fire;
    logic         bad_mode;
    logic [D-1:0] fire_target;

    // value[5:4] of the second put carries no meaning.
    logic unused_value;
    assign unused_value = ^value[5:4];

    always_comb begin
        abs_target = D'({hi_q, lo_q});
        // Signed cast before widening gives the sign extension of the offset.
        rel_target = prog_ctr + D'($signed(lo_q));
    end

    // Decode of the armed jump; only consulted when jmpEn arrives in StArmed.
    always_comb begin
        fire        = 1'b0;
        bad_mode    = 1'b0;
        fire_target = abs_target;
        unique case (mode_q)
            ModeAbs: begin
                fire = 1'b1;
            end
            ModeAbsIf: begin
                fire = branchFlag;
            end
            ModeRel: begin
                fire        = 1'b1;
                fire_target = rel_target;
            end
            ModeRsvd: begin
                bad_mode = 1'b1;
            end
            default: begin
                bad_mode = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= StEmpty;
            lo_q       <= 8'h00;
            hi_q       <= 4'h0;
            mode_q     <= ModeAbs;
            target     <= '0;
            absjump_en <= 1'b0;
            jump_taken <= 1'b0;
            err        <= 1'b0;
        end else begin
            absjump_en <= 1'b0;
            jump_taken <= 1'b0;
            err        <= 1'b0;
            if (jmpEn) begin
                // A put coinciding with the jump is dropped and flagged.
                state_q <= StEmpty;
                if (state_q == StArmed) begin
                    if (fire) begin
                        target     <= fire_target;
                        absjump_en <= 1'b1;
                        jump_taken <= 1'b1;
                    end
                    err <= bad_mode | putEn;
                end else begin
                    err <= 1'b1;
                end
            end else if (putEn) begin
                if (state_q == StLo) begin
                    mode_q  <= mode_e'(value[7:6]);
                    hi_q    <= value[3:0];
                    state_q <= StArmed;
                end else begin
                    lo_q    <= value;
                    state_q <= StLo;
                end
            end
        end
    end

    always_comb begin
        pending = 2'd0;
        unique case (state_q)
            StEmpty: pending = 2'd0;
            StLo:    pending = 2'd1;
            StArmed: pending = 2'd2;
            default: pending = 2'd0;
        endcase
    end

endmodule
